branch_resolver: RTL and testbench
==================================

# branch_resolver

Execute-side counterpart to the branch predictor. It records every prediction issued at decode in an in-order tracking queue. When execute evaluates a branch, it pops the matching entry, compares prediction with outcome, and produces the registered feedback packet (valid, pc, prediction, outcome) that trains the predictor. On a mispredict it also raises a one-cycle flush carrying the recovery target and discards all younger queued predictions.

## Interface
- ADDR_WIDTH, 32, PC and target width
- DEPTH, 4, tracking-queue entries (power of two, ≥2)
- CNT_WIDTH, 32, statistics counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_dec_valid  in  1  prediction issued this cycle (conditional branch, not jump)
- i_dec_pc  in  ADDR_WIDTH  branch PC
- i_dec_prediction  in  1  BranchOutcome (NOT_TAKEN=0, TAKEN=1)
- i_dec_recovery_target  in  ADDR_WIDTH  PC to fetch if the prediction is wrong
- o_dec_ready  out  1  queue not full; decode stalls when low
- i_ex_valid  in  1  branch resolved this cycle
- i_ex_pc  in  ADDR_WIDTH  PC of the resolved branch
- i_ex_outcome  in  1  actual BranchOutcome
- o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome  out  1/ADDR_WIDTH/1/1  feedback to predictor
- o_flush  out  1  mispredict recovery request
- o_recovery_target  out  ADDR_WIDTH  fetch redirect PC, valid when o_flush
- o_branch_count, o_miss_count  out  CNT_WIDTH  statistics
- o_underflow, o_order_err  out  1  sticky error flags

## Operation
- Queue: circular FIFO with head/tail pointers of log2(DEPTH) bits plus an occupancy count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- o_dec_ready = (count != DEPTH), combinational.
- Enqueue when i_dec_valid & o_dec_ready. i_dec_valid while full is ignored; decode must hold.
- Resolve when i_ex_valid & count != 0. Pop the head, compare with i_ex_outcome, and register the feedback on the next edge.
- Mispredict (head.prediction != i_ex_outcome):
  - On the next edge: o_flush=1 and o_recovery_target=head.recovery_target.
  - On that same edge, count/head/tail reset to 0, and any same-cycle enqueue is dropped (wrong path).
- Correct prediction with same-cycle enqueue and dequeue: count unchanged. This holds when full, so o_dec_ready stays low but the enqueue is accepted because a slot frees on the same edge.
- i_ex_valid with count==0: no feedback, no flush, o_underflow set.
- i_ex_pc != head.pc: feedback and flush still use head.prediction, and o_order_err is set.
- Statistics:
  - o_branch_count increments per resolved branch.
  - o_miss_count increments per mispredict.
  - Both saturate at all-ones.

## Timing
- Feedback latency: 1 cycle. o_fb_* and o_flush are registered and reflect the resolve of cycle t at cycle t+1.
- o_fb_valid and o_flush are single-cycle pulses. Back-to-back resolves yield back-to-back pulses. A flush at t+1 follows a queue clear at the t→t+1 edge, so a resolve at t+1 with an empty queue sets o_underflow.
- Enqueue-to-resolvable: an entry written at edge t is poppable in cycle t+1 (no bypass within the same cycle).
- Reset values: o_fb_valid=0, o_fb_pc=0, o_fb_prediction=0, o_fb_outcome=0, o_flush=0, o_recovery_target=0, o_branch_count=0, o_miss_count=0, o_underflow=0, o_order_err=0, o_dec_ready=1 (count=0).
- Reset mid-operation drops all queued entries and suppresses any pending feedback. Reset dominates all other events on the same edge.

## Configuration
- BRANCH_RESOLVER_STATS_EN defined: counters are implemented as described.
- Not defined: counter registers are removed and o_branch_count/o_miss_count are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then enqueue PC 0x100 predicted TAKEN with recovery 0x108; resolve TAKEN two cycles later -> one cycle later o_fb_valid=1, o_fb_pc=0x100, o_fb_outcome=1, o_flush=0, o_branch_count=1.
- Enqueue 0x200 (NOT_TAKEN, recovery 0x240) then 0x210; resolve 0x200 TAKEN -> o_flush=1, o_recovery_target=0x240, o_miss_count=1, queue empty (o_dec_ready=1); next resolve sets o_underflow.
- Enqueue DEPTH=4 entries -> o_dec_ready=0. A 5th i_dec_valid is ignored. Simultaneous correct resolve plus enqueue keeps count at 4, and the new entry is later popped fifth in order.
- Resolve with i_ex_pc=0x300 while head PC=0x304 -> feedback reports 0x304, and o_order_err stays 1 until reset.
- Assert rst_n=0 with 3 entries queued during a resolve -> next cycle all outputs are at their reset values with no o_fb_valid pulse; with BRANCH_RESOLVER_STATS_EN undefined, counters read 0 throughout.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver
//   Execute-side tracker for branch predictions. Every prediction issued at
//   decode is queued in order. When execute resolves a branch, the oldest
//   entry is popped and compared against the actual outcome. The result is a
//   registered feedback packet for the predictor. On a mispredict there is
//   also a one-cycle flush carrying the recovery target, and every younger
//   queued entry is discarded.
//
//   Optional feature macro: BRANCH_RESOLVER_STATS_EN
//     defined   -> saturating branch/miss counters are implemented
//     undefined -> counters are removed and the outputs are tied to 0
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   i_dec_*                        prediction issue from decode
//   o_dec_ready                    queue not full (combinational)
//   i_ex_valid/i_ex_pc/i_ex_outcome branch resolution from execute
//   o_fb_*                         registered training packet (1-cycle pulse)
//   o_flush/o_recovery_target      registered mispredict redirect (1-cycle pulse)
//   o_branch_count/o_miss_count    statistics
//   o_underflow/o_order_err        sticky error flags
module branch_resolver #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dec_valid,
  input  logic [ADDR_WIDTH-1:0] i_dec_pc,
  input  logic                  i_dec_prediction,
  input  logic [ADDR_WIDTH-1:0] i_dec_recovery_target,
  output logic                  o_dec_ready,
  input  logic                  i_ex_valid,
  input  logic [ADDR_WIDTH-1:0] i_ex_pc,
  input  logic                  i_ex_outcome,
  output logic                  o_fb_valid,
  output logic [ADDR_WIDTH-1:0] o_fb_pc,
  output logic                  o_fb_prediction,
  output logic                  o_fb_outcome,
  output logic                  o_flush,
  output logic [ADDR_WIDTH-1:0] o_recovery_target,
  output logic [CNT_WIDTH-1:0]  o_branch_count,
  output logic [CNT_WIDTH-1:0]  o_miss_count,
  output logic                  o_underflow,
  output logic                  o_order_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
    logic [ADDR_WIDTH-1:0] tgt;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic                  fb_valid_q, fb_pred_q, fb_out_q, flush_q, uf_q, oe_q;
  logic [ADDR_WIDTH-1:0] fb_pc_q, rtgt_q;

  entry_t head_e;
  logic   resolve, mispred, deq, enq;

  assign head_e      = mem_q[head_q];
  assign o_dec_ready = (count_q != FULL);
  assign resolve     = i_ex_valid && (count_q != '0);
  assign mispred     = resolve && (head_e.pred != i_ex_outcome);
  assign deq         = resolve && !mispred;
  // A correct resolve frees a slot on the same edge, so a full queue can
  // still accept; anything issued alongside a mispredict is wrong-path.
  assign enq         = i_dec_valid && !mispred && (o_dec_ready || deq);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispred) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) head_d = head_q + PTR_W'(1);
      if (enq) tail_d = tail_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= '{pc: i_dec_pc, pred: i_dec_prediction,
                                tgt: i_dec_recovery_target};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fb_valid_q <= 1'b0;
      fb_pc_q    <= '0;
      fb_pred_q  <= 1'b0;
      fb_out_q   <= 1'b0;
      flush_q    <= 1'b0;
      rtgt_q     <= '0;
      uf_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fb_valid_q <= resolve;
      flush_q    <= mispred;
      if (resolve) begin
        fb_pc_q   <= head_e.pc;
        fb_pred_q <= head_e.pred;
        fb_out_q  <= i_ex_outcome;
      end
      if (mispred) rtgt_q <= head_e.tgt;
      if (i_ex_valid && count_q == '0) uf_q <= 1'b1;
      if (resolve && i_ex_pc != head_e.pc) oe_q <= 1'b1;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_WIDTH-1:0] bcnt_q, mcnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (resolve && bcnt_q != '1) bcnt_q <= bcnt_q + CNT_WIDTH'(1);
      if (mispred && mcnt_q != '1) mcnt_q <= mcnt_q + CNT_WIDTH'(1);
    end
  end
  assign o_branch_count = bcnt_q;
  assign o_miss_count   = mcnt_q;
`else
  assign o_branch_count = '0;
  assign o_miss_count   = '0;
`endif

  assign o_fb_valid        = fb_valid_q;
  assign o_fb_pc           = fb_pc_q;
  assign o_fb_prediction   = fb_pred_q;
  assign o_fb_outcome      = fb_out_q;
  assign o_flush           = flush_q;
  assign o_recovery_target = rtgt_q;
  assign o_underflow       = uf_q;
  assign o_order_err       = oe_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver. A behavioural queue model produces the
// expected packet for each cycle; it is pushed to a scoreboard when the
// stimulus is driven and popped/compared after the clock edge.
module tb_branch_resolver;
  localparam int AW = 32, DEPTH = 4, CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_dec_valid, i_dec_prediction, i_ex_valid, i_ex_outcome;
  logic [AW-1:0] i_dec_pc, i_dec_recovery_target, i_ex_pc;
  logic          o_dec_ready, o_fb_valid, o_fb_prediction, o_fb_outcome;
  logic          o_flush, o_underflow, o_order_err;
  logic [AW-1:0] o_fb_pc, o_recovery_target;
  logic [CW-1:0] o_branch_count, o_miss_count;

  always #5 clk = ~clk;

  branch_resolver #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dec_valid(i_dec_valid), .i_dec_pc(i_dec_pc),
    .i_dec_prediction(i_dec_prediction),
    .i_dec_recovery_target(i_dec_recovery_target),
    .o_dec_ready(o_dec_ready),
    .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_outcome(i_ex_outcome),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc),
    .o_fb_prediction(o_fb_prediction), .o_fb_outcome(o_fb_outcome),
    .o_flush(o_flush), .o_recovery_target(o_recovery_target),
    .o_branch_count(o_branch_count), .o_miss_count(o_miss_count),
    .o_underflow(o_underflow), .o_order_err(o_order_err)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          pred;
    logic [AW-1:0] tgt;
  } ent_t;

  typedef struct packed {
    logic          fb_valid;
    logic [AW-1:0] fb_pc;
    logic          fb_pred;
    logic          fb_out;
    logic          flush;
    logic [AW-1:0] rtgt;
    logic          uf;
    logic          oe;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  logic          uf_m, oe_m;
  logic [CW-1:0] bc_m, mc_m;
  int n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // One clock of stimulus with model update and output comparison.
  task automatic step(input logic dv, input logic [AW-1:0] dpc, input logic dpred,
                      input logic [AW-1:0] dtgt, input logic ev,
                      input logic [AW-1:0] epc, input logic eout);
    exp_t e;
    ent_t h;
    logic res, mis, enq;
    i_dec_valid = dv; i_dec_pc = dpc; i_dec_prediction = dpred;
    i_dec_recovery_target = dtgt;
    i_ex_valid = ev; i_ex_pc = epc; i_ex_outcome = eout;
    #1 check("dec_ready", 64'(o_dec_ready), 64'(mq.size() != DEPTH));
    e = '0;
    res = ev && mq.size() != 0;
    mis = 1'b0;
    if (ev && mq.size() == 0) uf_m = 1'b1;
    if (res) begin
      h = mq[0];
      mis = (h.pred != eout);
      e.fb_valid = 1'b1; e.fb_pc = h.pc; e.fb_pred = h.pred; e.fb_out = eout;
      e.flush = mis; e.rtgt = h.tgt;
      if (epc != h.pc) oe_m = 1'b1;
      bc_m = sat_inc(bc_m);
      if (mis) mc_m = sat_inc(mc_m);
    end
    enq = dv && !mis && (mq.size() != DEPTH || res);
    if (mis) mq.delete();
    else begin
      if (res) void'(mq.pop_front());
      if (enq) mq.push_back('{pc: dpc, pred: dpred, tgt: dtgt});
    end
    e.uf = uf_m; e.oe = oe_m;
`ifdef BRANCH_RESOLVER_STATS_EN
    e.bc = bc_m; e.mc = mc_m;
`else
    e.bc = '0; e.mc = '0;
`endif
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("fb_valid", 64'(o_fb_valid), 64'(e.fb_valid));
    if (e.fb_valid) begin
      check("fb_pc", 64'(o_fb_pc), 64'(e.fb_pc));
      check("fb_prediction", 64'(o_fb_prediction), 64'(e.fb_pred));
      check("fb_outcome", 64'(o_fb_outcome), 64'(e.fb_out));
    end
    check("flush", 64'(o_flush), 64'(e.flush));
    if (e.flush) check("recovery_target", 64'(o_recovery_target), 64'(e.rtgt));
    check("underflow", 64'(o_underflow), 64'(e.uf));
    check("order_err", 64'(o_order_err), 64'(e.oe));
    check("branch_count", 64'(o_branch_count), 64'(e.bc));
    check("miss_count", 64'(o_miss_count), 64'(e.mc));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask
  task automatic enq(input logic [AW-1:0] pc, input logic pred, input logic [AW-1:0] tgt);
    step(1'b1, pc, pred, tgt, 1'b0, '0, 1'b0);
  endtask
  task automatic res(input logic [AW-1:0] pc, input logic out);
    step(1'b0, '0, 1'b0, '0, 1'b1, pc, out);
  endtask

  // Reset edge (inputs left as the caller set them), then check reset values.
  task automatic reset_edge();
    rst_n = 1'b0;
    @(posedge clk); #1;
    mq.delete(); uf_m = 1'b0; oe_m = 1'b0; bc_m = '0; mc_m = '0;
    check("rst_fb_valid", 64'(o_fb_valid), 64'd0);
    check("rst_fb_pc", 64'(o_fb_pc), 64'd0);
    check("rst_fb_pred", 64'(o_fb_prediction), 64'd0);
    check("rst_fb_out", 64'(o_fb_outcome), 64'd0);
    check("rst_flush", 64'(o_flush), 64'd0);
    check("rst_rtgt", 64'(o_recovery_target), 64'd0);
    check("rst_bc", 64'(o_branch_count), 64'd0);
    check("rst_mc", 64'(o_miss_count), 64'd0);
    check("rst_uf", 64'(o_underflow), 64'd0);
    check("rst_oe", 64'(o_order_err), 64'd0);
    check("rst_ready", 64'(o_dec_ready), 64'd1);
    rst_n = 1'b1;
  endtask

  initial begin
    i_dec_valid = 1'b0; i_dec_pc = '0; i_dec_prediction = 1'b0;
    i_dec_recovery_target = '0; i_ex_valid = 1'b0; i_ex_pc = '0; i_ex_outcome = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    reset_edge();

    // Correct TAKEN prediction
    enq(32'h100, 1'b1, 32'h108);
    idle();
    res(32'h100, 1'b1);

    // Mispredict flushes younger entry; following resolve underflows
    enq(32'h200, 1'b0, 32'h240);
    enq(32'h210, 1'b1, 32'h214);
    res(32'h200, 1'b1);
    res(32'h210, 1'b1);

    // Fill, ignored 5th, full enqueue+correct resolve, drain in order
    enq(32'h400, 1'b1, 32'h1);
    enq(32'h404, 1'b0, 32'h2);
    enq(32'h408, 1'b1, 32'h3);
    enq(32'h40c, 1'b0, 32'h4);
    enq(32'h410, 1'b1, 32'h5);
    step(1'b1, 32'h420, 1'b1, 32'h6, 1'b1, 32'h400, 1'b1);
    res(32'h404, 1'b0);
    res(32'h408, 1'b1);
    res(32'h40c, 1'b0);
    res(32'h420, 1'b1);
    idle();

    // Order error: resolve PC differs from head
    enq(32'h304, 1'b0, 32'h400);
    res(32'h300, 1'b0);
    idle();
    idle();

    // Same-cycle enqueue is dropped on a mispredict
    enq(32'h500, 1'b0, 32'h550);
    step(1'b1, 32'h510, 1'b1, 32'h514, 1'b1, 32'h500, 1'b1);
    res(32'h510, 1'b1);

    // Reset mid-operation with a resolve pending
    enq(32'h700, 1'b1, 32'h7);
    enq(32'h704, 1'b1, 32'h8);
    enq(32'h708, 1'b1, 32'h9);
    i_dec_valid = 1'b1; i_dec_pc = 32'h70c;
    i_ex_valid = 1'b1; i_ex_pc = 32'h700; i_ex_outcome = 1'b0;
    reset_edge();
    idle();

    // No same-cycle bypass: enqueue+resolve on empty queue underflows
    step(1'b1, 32'h600, 1'b1, 32'h604, 1'b1, 32'h600, 1'b1);
    res(32'h600, 1'b1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
